// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Brief    : Shared FSM states, Booth step selects and defaults for the
//            sequential Booth / shift-add multiplier.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package mult_pkg;

  // Operand width used when the parent does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states, kept as plain constants for legacy tool flows.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Radix-2 Booth step selects.
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Map the {q[0], q_m1} bit pair onto a Booth step select.
  function automatic logic [1:0] booth_decode(input logic q0, input logic qm1);
    logic [1:0] sel;
    case ({q0, qm1})
      2'b01:   sel = BOOTH_ADD;
      2'b10:   sel = BOOTH_SUB;
      default: sel = BOOTH_NOP;
    endcase
    return sel;
  endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_step_adder.sv
`default_nettype none
// ============================================================================
// Module   : mult_step_adder
// Brief    : Combinational WIDTH-bit adder with carry-in used for one
//            multiplier iteration. The carry-out is deliberately dropped:
//            the parent sizes the accumulator so the sum never overflows.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module mult_step_adder #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum
);

  assign o_sum = i_a + i_b + {{(WIDTH-1){1'b0}}, i_cin};

endmodule : mult_step_adder
`default_nettype wire

// File: rtl/seq_booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_booth_multiplier
// Brief    : WIDTH x WIDTH sequential multiplier, one iteration per clock.
//            Signed operands use radix-2 Booth recoding, unsigned operands
//            use plain shift-add. start/busy/done handshake; the product is
//            held in DONE until the next accepted start or reset.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module seq_booth_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_q;
  logic               r_qm1;
  logic [WIDTH-1:0]   r_y;
  logic               r_mode;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_result;

  logic [1:0]         w_sel;
  logic [WIDTH:0]     w_addend;
  logic               w_cin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_acc_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic               w_last;

  assign w_sel  = booth_decode(r_q[0], r_qm1);
  assign w_last = (r_cnt == CNT_W'(WIDTH));

  // Choose the step addend: sign-extended +/-y for Booth, zero-extended y for shift-add.
  always_comb begin
    w_addend = '0;
    w_cin    = 1'b0;
    if (r_mode) begin
      case (w_sel)
        BOOTH_ADD: w_addend = {r_y[WIDTH-1], r_y};
        BOOTH_SUB: begin
          // ~sext(y) + 1 in WIDTH+1 bits represents -y even for the most-negative y.
          w_addend = ~{r_y[WIDTH-1], r_y};
          w_cin    = 1'b1;
        end
        default:   w_addend = '0;
      endcase
    end else if (r_q[0]) begin
      w_addend = {1'b0, r_y};
    end
  end

  mult_step_adder #(
    .WIDTH (WIDTH + 1)
  ) u_step_adder (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .i_cin (w_cin),
    .o_sum (w_sum)
  );

  // Right shift of {sum, q}: arithmetic for signed mode, logical (zero fill) for unsigned.
  assign w_acc_nxt = {(r_mode ? w_sum[WIDTH] : 1'b0), w_sum[WIDTH:1]};
  assign w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};

  // Controller and datapath registers; reset wins over any operation in flight.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_qm1    <= 1'b0;
      r_y      <= '0;
      r_mode   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= x;
            r_qm1   <= 1'b0;
            r_y     <= y;
            r_mode  <= signed_mode;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          // start is ignored here; the operation in flight always runs to completion.
          if (w_last) begin
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= {r_acc[WIDTH-1:0], r_q};
          end else begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_qm1 <= r_q[0];
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule : seq_booth_multiplier
`default_nettype wire

// File: tb/tb_seq_booth_multiplier.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seq_booth_multiplier
// Brief    : Self-checking bench for seq_booth_multiplier at WIDTH=8 and 16
//            against an integer-arithmetic reference product.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_booth_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  x8, y8;
  logic [15:0] result8;
  logic        start16, sm16, busy16, done16;
  logic [15:0] x16, y16;
  logic [31:0] result16;

  int n_checks = 0;
  int n_fail   = 0;

  seq_booth_multiplier #(.WIDTH(8)) u_dut8 (
    .clk (clk), .res (res), .start (start8), .signed_mode (sm8),
    .x (x8), .y (y8), .busy (busy8), .done (done8), .result (result8)
  );

  seq_booth_multiplier #(.WIDTH(16)) u_dut16 (
    .clk (clk), .res (res), .start (start16), .signed_mode (sm16),
    .x (x16), .y (y16), .busy (busy16), .done (done16), .result (result16)
  );

  // Reference: interpret operands as integers, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_prod(input bit sm, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
    longint sa, sb, p;
    logic [63:0] mask;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  // Operand picker biased towards boundary values.
  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1 << (w - 1);
      2:       return (32'd1 << (w - 1)) - 32'd1;
      3:       return mask;
      default: return $urandom & mask;
    endcase
  endfunction

  // Present an operation for one edge; returns 1 ns after the accepting edge.
  task automatic go8(input bit sm, input logic [7:0] a, input logic [7:0] b);
    sm8 = sm; x8 = a; y8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; sm8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom);
  endtask

  task automatic go16(input bit sm, input logic [15:0] a, input logic [15:0] b);
    sm16 = sm; x16 = a; y16 = b; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; sm16 = 1'($urandom); x16 = 16'($urandom); y16 = 16'($urandom);
  endtask

  // Count edges until done rises, bounded.
  task automatic wait8(output int edges);
    edges = 0;
    while (!done8 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic wait16(output int edges);
    edges = 0;
    while (!done16 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done8 got=%b exp=0", done8); end
    n_checks++; if (result8 !== 16'h0) begin n_fail++; $display("FAIL reset_result8 got=%h exp=0", result8); end
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy16 got=%b exp=0", busy16); end
    n_checks++; if (done16 !== 1'b0) begin n_fail++; $display("FAIL reset_done16 got=%b exp=0", done16); end
    n_checks++; if (result16 !== 32'h0) begin n_fail++; $display("FAIL reset_result16 got=%h exp=0", result16); end
    res = 1'b0;
  endtask

  task automatic test_signed_basic();
    int e;
    logic [63:0] exp;
    exp = ref_prod(1'b1, 32'hFD, 32'h05, 8);
    go8(1'b1, 8'hFD, 8'h05);
    n_checks++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin n_fail++; $display("FAIL basic_load got busy=%b done=%b exp busy=1 done=0", busy8, done8); end
    wait8(e);
    n_checks++; if (e !== 9) begin n_fail++; $display("FAIL basic_latency got=%0d exp=9", e); end
    n_checks++; if (result8 !== exp[15:0]) begin n_fail++; $display("FAIL basic_result got=%h exp=%h", result8, exp[15:0]); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (done8 !== 1'b1 || busy8 !== 1'b0 || result8 !== exp[15:0]) begin
      n_fail++; $display("FAIL basic_hold got done=%b busy=%b res=%h exp done=1 busy=0 res=%h", done8, busy8, result8, exp[15:0]);
    end
  endtask

  task automatic test_boundaries();
    logic [16:0] vec [6];
    int e;
    logic [63:0] exp;
    vec = '{{1'b1, 8'h80, 8'h80}, {1'b1, 8'h80, 8'h7F}, {1'b0, 8'hFF, 8'hFF},
            {1'b1, 8'hFF, 8'hFF}, {1'b1, 8'h7F, 8'h80}, {1'b0, 8'h00, 8'hFF}};
    for (int i = 0; i < 6; i++) begin
      exp = ref_prod(vec[i][16], {24'h0, vec[i][15:8]}, {24'h0, vec[i][7:0]}, 8);
      go8(vec[i][16], vec[i][15:8], vec[i][7:0]);
      wait8(e);
      n_checks++; if (result8 !== exp[15:0]) begin
        n_fail++; $display("FAIL boundary_%0d got=%h exp=%h (e=%0d)", i, result8, exp[15:0], e);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int e;
    logic [63:0] exp;
    exp = ref_prod(1'b1, 32'h9C, 32'h37, 8);
    go8(1'b1, 8'h9C, 8'h37);
    repeat (3) @(posedge clk);
    #1;
    start8 = 1'b1; sm8 = 1'b0; x8 = 8'h11; y8 = 8'h22;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait8(e);
    n_checks++; if (e + 4 !== 9) begin n_fail++; $display("FAIL busy_start_latency got=%0d exp=9", e + 4); end
    n_checks++; if (result8 !== exp[15:0]) begin n_fail++; $display("FAIL busy_start_result got=%h exp=%h", result8, exp[15:0]); end
  endtask

  task automatic test_back_to_back();
    int e;
    logic [63:0] exp;
    go8(1'b0, 8'hC3, 8'h5A);
    wait8(e);
    exp = ref_prod(1'b1, 32'hA5, 32'h3C, 8);
    go8(1'b1, 8'hA5, 8'h3C);
    n_checks++; if (done8 !== 1'b0 || busy8 !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got done=%b busy=%b exp done=0 busy=1", done8, busy8); end
    wait8(e);
    n_checks++; if (e !== 9) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=9", e); end
    n_checks++; if (result8 !== exp[15:0]) begin n_fail++; $display("FAIL b2b_result got=%h exp=%h", result8, exp[15:0]); end
  endtask

  task automatic test_reset_mid_op();
    int e;
    logic [63:0] exp;
    go8(1'b1, 8'h87, 8'h6E);
    repeat (3) @(posedge clk);
    #1;
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", busy8); end
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL midreset_done got=%b exp=0", done8); end
    n_checks++; if (result8 !== 16'h0) begin n_fail++; $display("FAIL midreset_result got=%h exp=0", result8); end
    exp = ref_prod(1'b0, 32'h9A, 32'hE7, 8);
    go8(1'b0, 8'h9A, 8'hE7);
    wait8(e);
    n_checks++; if (e !== 9) begin n_fail++; $display("FAIL midreset_new_latency got=%0d exp=9", e); end
    n_checks++; if (result8 !== exp[15:0]) begin n_fail++; $display("FAIL midreset_new_result got=%h exp=%h", result8, exp[15:0]); end
  endtask

  task automatic test_width16();
    int e;
    logic [63:0] exp;
    exp = ref_prod(1'b1, 32'h8000, 32'h7FFF, 16);
    go16(1'b1, 16'h8000, 16'h7FFF);
    wait16(e);
    n_checks++; if (e !== 17) begin n_fail++; $display("FAIL w16_latency got=%0d exp=17", e); end
    n_checks++; if (result16 !== exp[31:0]) begin n_fail++; $display("FAIL w16_result got=%h exp=%h", result16, exp[31:0]); end
  endtask

  task automatic test_random8(input int n);
    int e;
    bit sm;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < n; i++) begin
      sm = 1'($urandom); a = pick(8); b = pick(8);
      exp = ref_prod(sm, a, b, 8);
      go8(sm, a[7:0], b[7:0]);
      wait8(e);
      n_checks++; if (e !== 9) begin n_fail++; $display("FAIL rand8_latency op=%0d got=%0d exp=9", i, e); end
      n_checks++; if (result8 !== exp[15:0]) begin
        n_fail++; $display("FAIL rand8_result op=%0d sm=%b x=%h y=%h got=%h exp=%h", i, sm, a[7:0], b[7:0], result8, exp[15:0]);
      end
    end
  endtask

  task automatic test_random16(input int n);
    int e;
    bit sm;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < n; i++) begin
      sm = 1'($urandom); a = pick(16); b = pick(16);
      exp = ref_prod(sm, a, b, 16);
      go16(sm, a[15:0], b[15:0]);
      wait16(e);
      n_checks++; if (e !== 17) begin n_fail++; $display("FAIL rand16_latency op=%0d got=%0d exp=17", i, e); end
      n_checks++; if (result16 !== exp[31:0]) begin
        n_fail++; $display("FAIL rand16_result op=%0d sm=%b x=%h y=%h got=%h exp=%h", i, sm, a[15:0], b[15:0], result16, exp[31:0]);
      end
    end
  endtask

  initial begin
    res = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; x8 = '0; y8 = '0;
    start16 = 1'b0; sm16 = 1'b0; x16 = '0; y16 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_signed_basic();
    test_boundaries();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_width16();
    test_random8(1500);
    test_random16(800);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_seq_booth_multiplier
`default_nettype wire
